// File: rtl/ccu_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop, looks the line up in the cache,
// answers on CR, streams the line on CD when required and issues the state update.
module ccu_snoop_responder #(
  parameter int DcacheLineWidth = 128,
  parameter int AxiDataWidth    = 64,
  parameter int AddrWidth       = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AddrWidth-1:0]       ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [AxiDataWidth-1:0]    cd_data_o,
  output logic                       cd_last_o,
  output logic                       lkp_req_o,
  input  logic                       lkp_gnt_i,
  output logic [AddrWidth-1:0]       lkp_addr_o,
  input  logic                       lkp_rvalid_i,
  input  logic                       lkp_hit_i,
  input  logic                       lkp_dirty_i,
  input  logic                       lkp_shared_i,
  input  logic [DcacheLineWidth-1:0] lkp_data_i,
  output logic                       upd_valid_o,
  output logic [1:0]                 upd_op_o,
  output logic [AddrWidth-1:0]       upd_addr_o
);

  localparam int DcacheLineWords = DcacheLineWidth / AxiDataWidth;
  localparam int LineOffBits     = $clog2(DcacheLineWidth / 8);
  localparam int CntW            = (DcacheLineWords > 1) ? $clog2(DcacheLineWords) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DcacheLineWords - 1);

  localparam logic [3:0] SnpReadOnce     = 4'b0000;
  localparam logic [3:0] SnpReadShared   = 4'b0001;
  localparam logic [3:0] SnpReadUnique   = 4'b0111;
  localparam logic [3:0] SnpCleanInvalid = 4'b1001;
  localparam logic [3:0] SnpMakeInvalid  = 4'b1101;

  localparam logic [1:0] UpdNone   = 2'd0;
  localparam logic [1:0] UpdShared = 2'd1;
  localparam logic [1:0] UpdInval  = 2'd2;

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_RD, RESP, DATA} state_e;

  state_e                           state_q, state_d;
  logic [AddrWidth-LineOffBits-1:0] addr_q, addr_d;
  logic [3:0]                       snoop_q, snoop_d;
  logic [DcacheLineWidth-1:0]       line_q, line_d;
  logic [4:0]                       resp_q, resp_d;
  logic [1:0]                       op_q, op_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;

  logic [AddrWidth-1:0] line_addr;
  logic [4:0]           lkp_resp;
  logic [1:0]           lkp_op;
  logic                 supported, dt, is_shared, pass_dirty;
  logic [1:0]           hit_op;

  assign line_addr = {addr_q, {LineOffBits{1'b0}}};

  // Response and update decode from the snoop type and the live lookup result.
  always_comb begin
    supported  = 1'b1;
    dt         = 1'b0;
    is_shared  = 1'b0;
    pass_dirty = 1'b0;
    hit_op     = UpdNone;
    case (snoop_q)
      SnpReadOnce: begin
        dt        = 1'b1;
        is_shared = 1'b1;
      end
      SnpReadShared: begin
        dt         = 1'b1;
        is_shared  = 1'b1;
        pass_dirty = lkp_dirty_i;
        hit_op     = UpdShared;
      end
      SnpReadUnique: begin
        dt         = 1'b1;
        pass_dirty = lkp_dirty_i;
        hit_op     = UpdInval;
      end
      SnpCleanInvalid: begin
        dt         = lkp_dirty_i;
        pass_dirty = lkp_dirty_i;
        hit_op     = UpdInval;
      end
      SnpMakeInvalid: hit_op = UpdInval;
      default:        supported = 1'b0;
    endcase
    if (!supported) begin
      lkp_resp = 5'b00010;
      lkp_op   = UpdNone;
    end else if (!lkp_hit_i) begin
      lkp_resp = 5'b00000;
      lkp_op   = UpdNone;
    end else begin
      lkp_resp = {!lkp_shared_i, is_shared, pass_dirty, 1'b0, dt};
      lkp_op   = hit_op;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    line_d      = line_q;
    resp_d      = resp_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    ac_ready_o  = 1'b0;
    cr_valid_o  = 1'b0;
    cr_resp_o   = '0;
    cd_valid_o  = 1'b0;
    cd_data_o   = '0;
    cd_last_o   = 1'b0;
    lkp_req_o   = 1'b0;
    lkp_addr_o  = '0;
    upd_valid_o = 1'b0;
    upd_op_o    = UpdNone;
    upd_addr_o  = '0;
    case (state_q)
      IDLE: begin
        // The state register is already IDLE during reset; keep ready low too.
        ac_ready_o = !rst_i;
        if (ac_valid_i) begin
          addr_d  = ac_addr_i[AddrWidth-1:LineOffBits];
          snoop_d = ac_snoop_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        lkp_req_o  = 1'b1;
        lkp_addr_o = line_addr;
        if (lkp_gnt_i) state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (lkp_rvalid_i) begin
          line_d  = lkp_data_i;
          resp_d  = lkp_resp;
          op_d    = lkp_op;
          state_d = RESP;
        end
      end
      RESP: begin
        cr_valid_o = 1'b1;
        cr_resp_o  = resp_q;
        if (cr_ready_i) begin
          upd_valid_o = (op_q != UpdNone);
          upd_op_o    = (op_q != UpdNone) ? op_q : UpdNone;
          upd_addr_o  = (op_q != UpdNone) ? line_addr : '0;
          state_d     = resp_q[0] ? DATA : IDLE;
        end
      end
      DATA: begin
        cd_valid_o = 1'b1;
        cd_data_o  = line_q[cnt_q*AxiDataWidth +: AxiDataWidth];
        cd_last_o  = (cnt_q == LastCnt);
        if (cd_ready_i) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      snoop_q <= '0;
      line_q  <= '0;
      resp_q  <= '0;
      op_q    <= UpdNone;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      line_q  <= line_d;
      resp_q  <= resp_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// Randomized and directed bench for ccu_snoop_responder, checked against a
// snoop-rule reference model and a cycle-level cache/CCU environment.
module tb_ccu_snoop_responder;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int LW    = 128;
  localparam int WORDS = LW / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ac_valid = 1'b0, ac_ready;
  logic [AW-1:0] ac_addr = '0;
  logic [3:0]    ac_snoop = '0;
  logic          cr_valid, cr_ready = 1'b0;
  logic [4:0]    cr_resp;
  logic          cd_valid, cd_ready = 1'b0;
  logic [DW-1:0] cd_data;
  logic          cd_last;
  logic          lkp_req, lkp_gnt = 1'b0;
  logic [AW-1:0] lkp_addr;
  logic          lkp_rvalid = 1'b0, lkp_hit = 1'b0, lkp_dirty = 1'b0, lkp_shared = 1'b0;
  logic [LW-1:0] lkp_data = '0;
  logic          upd_valid;
  logic [1:0]    upd_op;
  logic [AW-1:0] upd_addr;

  int errors = 0;
  int checks = 0;

  // Per-transaction observations filled in by run_snoop
  logic [AW-1:0] o_lkp_addr, o_upd_addr;
  logic [4:0]    o_resp;
  logic [1:0]    o_upd_op;
  int o_upd_cnt, o_beats, o_data_bad, o_last_bad, o_cr_lat, o_cd_gap, o_end_gap;
  bit o_unstable, o_overlap, o_busy, o_timeout;

  ccu_snoop_responder dut (
    .clk_i(clk), .rst_i(rst),
    .ac_valid_i(ac_valid), .ac_ready_o(ac_ready), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
    .cr_valid_o(cr_valid), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp),
    .cd_valid_o(cd_valid), .cd_ready_i(cd_ready), .cd_data_o(cd_data), .cd_last_o(cd_last),
    .lkp_req_o(lkp_req), .lkp_gnt_i(lkp_gnt), .lkp_addr_o(lkp_addr),
    .lkp_rvalid_i(lkp_rvalid), .lkp_hit_i(lkp_hit), .lkp_dirty_i(lkp_dirty),
    .lkp_shared_i(lkp_shared), .lkp_data_i(lkp_data),
    .upd_valid_o(upd_valid), .upd_op_o(upd_op), .upd_addr_o(upd_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: returns {update op, CR response} from the snoop rules
  function automatic logic [6:0] model(input logic [3:0] s, input logic h, d, sh);
    logic known, dt, is_sh, pd;
    logic [1:0] op;
    known = 1'b1; dt = 1'b0; is_sh = 1'b0; pd = 1'b0; op = 2'd0;
    case (s)
      4'b0000: begin dt = 1'b1; is_sh = 1'b1; end
      4'b0001: begin dt = 1'b1; is_sh = 1'b1; pd = d; op = 2'd1; end
      4'b0111: begin dt = 1'b1; pd = d; op = 2'd2; end
      4'b1001: begin dt = d; pd = d; op = 2'd2; end
      4'b1101: op = 2'd2;
      default: known = 1'b0;
    endcase
    if (!known) return {2'd0, 5'b00010};
    if (!h) return 7'd0;
    return {op, !sh, is_sh, pd, 1'b0, dt};
  endfunction

  function automatic logic [DW-1:0] word_of(input logic [LW-1:0] ln, input int i);
    if (i < 0 || i >= WORDS) return 'x;
    return ln[i*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] outs_or();
    return {AW{1'b0}} | {ac_ready, cr_valid, cr_resp, cd_valid, cd_last, lkp_req,
                         upd_valid, upd_op} | cd_data | lkp_addr | upd_addr;
  endfunction

  // Acts as both the CCU and the cache for one snoop, recording what it sees
  task automatic run_snoop(input logic [AW-1:0] a, input logic [3:0] s,
                           input logic h, d, sh, input logic [LW-1:0] ln,
                           input int gnt_dly, rv_dly, cr_dly, stall);
    int hs_cyc, cr_first, cr_hs, cd_first, last_hs, done_cyc, gw, rw, cw, st, beat;
    bit sent, granted, rv_done, done;
    logic [4:0] r0;
    hs_cyc = 0; cr_first = -1; cr_hs = -1; cd_first = -1; last_hs = -1; done_cyc = -1;
    gw = 0; rw = 0; cw = 0; st = 0; beat = 0;
    sent = 0; granted = 0; rv_done = 0; done = 0; r0 = '0;
    o_lkp_addr = '0; o_upd_addr = '0; o_resp = '0; o_upd_op = '0;
    o_upd_cnt = 0; o_data_bad = 0; o_last_bad = 0;
    o_unstable = 0; o_overlap = 0; o_busy = 0; o_timeout = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      ac_valid = 1'b0; lkp_gnt = 1'b0; lkp_rvalid = 1'b0; cr_ready = 1'b0; cd_ready = 1'b0;
      if (!sent) begin
        if (ac_ready) begin
          ac_valid = 1'b1; ac_addr = a; ac_snoop = s; sent = 1; hs_cyc = cyc;
        end
      end else if (ac_ready) begin
        done = 1; done_cyc = cyc;
        break;
      end
      if (lkp_req) begin
        o_lkp_addr = lkp_addr;
        if (gw >= gnt_dly) begin lkp_gnt = 1'b1; granted = 1; end
        gw++;
      end else if (granted && !rv_done) begin
        if (rw >= rv_dly) begin
          lkp_rvalid = 1'b1; lkp_hit = h; lkp_dirty = d; lkp_shared = sh; lkp_data = ln;
          rv_done = 1;
        end
        rw++;
      end
      if (cr_valid) begin
        if (cr_first < 0) begin cr_first = cyc; r0 = cr_resp; end
        else if (cr_resp !== r0) o_unstable = 1;
        o_resp = cr_resp;
        if (cw >= cr_dly) begin cr_ready = 1'b1; cr_hs = cyc; end
        cw++;
      end
      if (cd_valid) begin
        if (cd_first < 0) cd_first = cyc;
        if (cd_data !== word_of(ln, beat)) o_data_bad++;
        if (cd_last !== (beat == WORDS - 1)) o_last_bad++;
        cd_ready = (beat == 0) || (st >= stall);
        st++;
        if (cd_ready) begin
          if (cd_last) last_hs = cyc;
          beat++; st = 0;
        end
      end
      #1;
      if (upd_valid) begin o_upd_cnt++; o_upd_op = upd_op; o_upd_addr = upd_addr; end
      if (cr_valid && cd_valid) o_overlap = 1;
      if (ac_ready && (lkp_req || cr_valid || cd_valid)) o_busy = 1;
    end
    o_timeout = !done;
    o_beats   = beat;
    o_cr_lat  = cr_first - hs_cyc;
    o_cd_gap  = (cd_first >= 0) ? cd_first - cr_hs : -1;
    o_end_gap = (last_hs >= 0) ? done_cyc - last_hs : -1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (outs_or() !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", outs_or());
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (ac_ready !== 1'b1) begin errors++; $display("FAIL reset_ac_ready got=%b exp=1", ac_ready); end
  endtask

  task automatic test_read_shared();
    logic [LW-1:0] ln;
    ln = rand_line();
    run_snoop(64'h1008, 4'b0001, 1'b1, 1'b0, 1'b0, ln, 0, 0, 0, 0);
    checks++; if (o_timeout) begin errors++; $display("FAIL rs_timeout got=1 exp=0"); end
    checks++; if (o_lkp_addr !== 64'h1000) begin errors++; $display("FAIL rs_lkp_addr got=%h exp=1000", o_lkp_addr); end
    checks++; if (o_resp !== 5'b11001) begin errors++; $display("FAIL rs_resp got=%b exp=11001", o_resp); end
    checks++; if (o_cr_lat !== 3) begin errors++; $display("FAIL rs_cr_latency got=%0d exp=3", o_cr_lat); end
    checks++; if (o_cd_gap !== 1) begin errors++; $display("FAIL rs_cd_gap got=%0d exp=1", o_cd_gap); end
    checks++; if (o_beats !== 2 || o_data_bad != 0 || o_last_bad != 0) begin
      errors++; $display("FAIL rs_cd beats=%0d databad=%0d lastbad=%0d exp=2/0/0", o_beats, o_data_bad, o_last_bad);
    end
    checks++; if (o_upd_cnt !== 1 || o_upd_op !== 2'd1 || o_upd_addr !== 64'h1000) begin
      errors++; $display("FAIL rs_upd cnt=%0d op=%0d addr=%h exp=1/1/1000", o_upd_cnt, o_upd_op, o_upd_addr);
    end
  endtask

  task automatic test_read_unique();
    run_snoop(64'h2040, 4'b0111, 1'b1, 1'b1, 1'b1, rand_line(), 1, 2, 2, 0);
    checks++; if (o_resp !== 5'b00101 || o_unstable) begin
      errors++; $display("FAIL ru_resp got=%b unstable=%0d exp=00101/0", o_resp, o_unstable);
    end
    checks++; if (o_beats !== 2 || o_data_bad != 0 || o_overlap) begin
      errors++; $display("FAIL ru_cd beats=%0d databad=%0d overlap=%0d exp=2/0/0", o_beats, o_data_bad, o_overlap);
    end
    checks++; if (o_upd_cnt !== 1 || o_upd_op !== 2'd2) begin
      errors++; $display("FAIL ru_upd cnt=%0d op=%0d exp=1/2", o_upd_cnt, o_upd_op);
    end
  endtask

  task automatic test_clean_invalid();
    run_snoop(64'h3000, 4'b1001, 1'b1, 1'b0, 1'b0, rand_line(), 0, 0, 0, 0);
    checks++; if (o_resp !== 5'b10000) begin errors++; $display("FAIL ci_resp got=%b exp=10000", o_resp); end
    checks++; if (o_beats !== 0) begin errors++; $display("FAIL ci_beats got=%0d exp=0", o_beats); end
    checks++; if (o_upd_cnt !== 1 || o_upd_op !== 2'd2) begin
      errors++; $display("FAIL ci_upd cnt=%0d op=%0d exp=1/2", o_upd_cnt, o_upd_op);
    end
  endtask

  task automatic test_miss_unknown();
    run_snoop(64'h4010, 4'b0000, 1'b0, 1'b1, 1'b0, rand_line(), 0, 1, 0, 0);
    checks++; if (o_resp !== 5'b00000 || o_beats !== 0 || o_upd_cnt !== 0) begin
      errors++; $display("FAIL miss got resp=%b beats=%0d upd=%0d exp=00000/0/0", o_resp, o_beats, o_upd_cnt);
    end
    run_snoop(64'h5020, 4'b0011, 1'b1, 1'b1, 1'b0, rand_line(), 0, 0, 0, 0);
    checks++; if (o_resp !== 5'b00010 || o_beats !== 0 || o_upd_cnt !== 0) begin
      errors++; $display("FAIL unknown got resp=%b beats=%0d upd=%0d exp=00010/0/0", o_resp, o_beats, o_upd_cnt);
    end
  endtask

  task automatic test_backpressure();
    run_snoop(64'h6000, 4'b0000, 1'b1, 1'b0, 1'b1, rand_line(), 0, 0, 0, 3);
    checks++; if (o_beats !== 2 || o_data_bad != 0 || o_last_bad != 0) begin
      errors++; $display("FAIL bp_cd beats=%0d databad=%0d lastbad=%0d exp=2/0/0", o_beats, o_data_bad, o_last_bad);
    end
    checks++; if (o_resp !== 5'b01001 || o_upd_cnt !== 0) begin
      errors++; $display("FAIL bp_resp got=%b upd=%0d exp=01001/0", o_resp, o_upd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    run_snoop(64'h7000, 4'b0001, 1'b1, 1'b1, 1'b0, rand_line(), 0, 0, 0, 0);
    checks++; if (o_end_gap !== 1) begin errors++; $display("FAIL b2b_idle_gap got=%0d exp=1", o_end_gap); end
    run_snoop(64'h7040, 4'b1101, 1'b1, 1'b1, 1'b0, rand_line(), 0, 0, 0, 0);
    checks++; if (o_cr_lat !== 3 || o_resp !== 5'b10000 || o_upd_op !== 2'd2) begin
      errors++; $display("FAIL b2b_second lat=%0d resp=%b op=%0d exp=3/10000/2", o_cr_lat, o_resp, o_upd_op);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [LW-1:0] ln;
    ln = rand_line();
    @(negedge clk); ac_valid = 1'b1; ac_addr = 64'h8000; ac_snoop = 4'b0001;
    @(negedge clk); ac_valid = 1'b0; lkp_gnt = 1'b1;
    @(negedge clk); lkp_gnt = 1'b0; lkp_rvalid = 1'b1; lkp_hit = 1'b1; lkp_dirty = 1'b0;
    lkp_shared = 1'b0; lkp_data = ln;
    @(negedge clk); lkp_rvalid = 1'b0; cr_ready = 1'b1;
    @(negedge clk); cr_ready = 1'b0; cd_ready = 1'b0; #1;
    checks++; if (cd_valid !== 1'b1 || cd_data !== ln[63:0]) begin
      errors++; $display("FAIL rmb_stall cd_valid=%b data=%h exp=1/%h", cd_valid, cd_data, ln[63:0]);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (outs_or() !== '0) begin errors++; $display("FAIL rmb_reset_outputs got=%h exp=0", outs_or()); end
    @(negedge clk); lkp_rvalid = 1'b1; #1;
    checks++; if (outs_or() !== '0) begin errors++; $display("FAIL rmb_reset_held got=%h exp=0", outs_or()); end
    @(negedge clk); lkp_rvalid = 1'b0; rst = 1'b0; #1;
    checks++; if (ac_ready !== 1'b1) begin errors++; $display("FAIL rmb_ac_ready got=%b exp=1", ac_ready); end
    @(negedge clk); lkp_rvalid = 1'b1;
    @(negedge clk); lkp_rvalid = 1'b0; #1;
    checks++; if (ac_ready !== 1'b1 || cr_valid !== 1'b0) begin
      errors++; $display("FAIL rmb_stale_rvalid ac_ready=%b cr_valid=%b exp=1/0", ac_ready, cr_valid);
    end
    ln = rand_line();
    run_snoop(64'h9030, 4'b0000, 1'b1, 1'b0, 1'b0, ln, 0, 0, 0, 1);
    checks++; if (o_resp !== 5'b11001 || o_beats !== 2 || o_data_bad != 0 || o_timeout) begin
      errors++; $display("FAIL rmb_fresh resp=%b beats=%0d databad=%0d to=%0d exp=11001/2/0/0",
                         o_resp, o_beats, o_data_bad, o_timeout);
    end
  endtask

  task automatic test_random();
    logic [3:0] codes [6];
    logic [3:0] s;
    logic [AW-1:0] a;
    logic h, d, sh;
    logic [6:0] m;
    int g, r, c, st;
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0111;
    codes[3] = 4'b1001; codes[4] = 4'b1101; codes[5] = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      codes[5] = 4'($urandom);
      s  = codes[$urandom_range(0, 5)];
      a  = {$urandom, $urandom};
      h  = 1'($urandom); d = 1'($urandom); sh = 1'($urandom);
      g  = $urandom_range(0, 3); r = $urandom_range(0, 3);
      c  = $urandom_range(0, 3); st = $urandom_range(0, 3);
      m  = model(s, h, d, sh);
      run_snoop(a, s, h, d, sh, rand_line(), g, r, c, st);
      checks++;
      if (o_timeout || o_resp !== m[4:0] || o_cr_lat != 3 + g + r || o_lkp_addr !== (a & ~64'hF)) begin
        errors++;
        $display("FAIL rand_resp i=%0d snp=%b to=%0d resp=%b exp=%b lat=%0d exp=%0d lkp=%h",
                 i, s, o_timeout, o_resp, m[4:0], o_cr_lat, 3 + g + r, o_lkp_addr);
      end
      checks++;
      if (o_upd_cnt != ((m[6:5] != 2'd0) ? 1 : 0) || (m[6:5] != 2'd0 &&
          (o_upd_op !== m[6:5] || o_upd_addr !== (a & ~64'hF)))) begin
        errors++;
        $display("FAIL rand_upd i=%0d cnt=%0d op=%0d addr=%h exp_op=%0d", i, o_upd_cnt, o_upd_op, o_upd_addr, m[6:5]);
      end
      checks++;
      if (o_beats != (m[0] ? WORDS : 0) || o_data_bad != 0 || o_last_bad != 0 ||
          o_overlap || o_busy || o_unstable) begin
        errors++;
        $display("FAIL rand_cd i=%0d beats=%0d exp=%0d databad=%0d lastbad=%0d ovl=%0d busy=%0d unst=%0d",
                 i, o_beats, m[0] ? WORDS : 0, o_data_bad, o_last_bad, o_overlap, o_busy, o_unstable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_shared();
    test_read_unique();
    test_clean_invalid();
    test_miss_unknown();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
